// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for the 32x4 DPRAM FIFO controller.
// The master side is the producer/consumer pair. The controller uses the slave side.
interface dpram_fifo_ctrl_if #(
    parameter int DW = 4
);
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller in front of a distributed dual-port RAM.
// The controller holds only the pointers, the occupancy count and the status flags.
// All data lives in the RAM. Its asynchronous read port supplies the head entry directly.
module dpram_fifo_ctrl #(
    parameter int AW       = 5,
    parameter int DW       = 4,
    parameter int AF_LEVEL = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    dpram_fifo_ctrl_if.slave        bus,
    output logic [AW:0]             count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic [AW-1:0]           ram_a,
    output logic [DW-1:0]           ram_d,
    output logic                    ram_we,
    output logic [AW-1:0]           ram_dpra,
    input  logic [DW-1:0]           ram_dpo
);

    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_THRESH = AF_LEVEL[AW:0];

    // Each pointer has AW address bits plus a wrap bit on top.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] count_nxt;
    logic        push;
    logic        pop;

    // Handshakes. While rst_n is low, wr_ready is held at 0, so no write can reach the RAM during reset.
    assign bus.wr_ready = rst_n & ~full & ~flush;
    assign bus.rd_valid = ~empty & ~flush;
    assign push         = bus.wr_valid & bus.wr_ready;
    assign pop          = bus.rd_valid & bus.rd_ready;

    // The RAM write happens on the same edge that advances wptr.
    assign ram_we       = push;
    assign ram_a        = wptr[AW-1:0];
    assign ram_d        = bus.wr_data;
    assign ram_dpra     = rptr[AW-1:0];
    assign bus.rd_data  = ram_dpo;

    // Next occupancy. Flush wins over push and pop in the same cycle. A push and pop together leave the count unchanged.
    always_comb begin
        // NOTE: assign a default first so that no path through the block infers a latch.
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + PTR_ONE;
        else if (pop && !push)
            count_nxt = count - PTR_ONE;
    end

    // Pointer, occupancy and flag registers. The flags come from count_nxt, so they are exact in the same cycle as count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + PTR_ONE;
                if (pop)  rptr <= rptr + PTR_ONE;
            end
            count       <= count_nxt;
            full        <= (count_nxt == DEPTH);
            empty       <= (count_nxt == '0);
            almost_full <= (count_nxt >= AF_THRESH);
        end
    end

    // The pointer distance, including the wrap bits, must always equal the occupancy.
    a_occupancy: assert property (@(posedge clk) disable iff (!rst_n) (wptr - rptr) == count);

endmodule
